jam_cost_table: RTL and testbench

- Upstream cost store for the job-assignment solver. Loads an N x N worker/job cost matrix from a streaming load port, then answers the solver's (W, J) lookups with a registered Cost.
- Sits directly upstream of the solver, which drives W/J and samples Cost.
- Also reports load progress and a running checksum for bench cross-checking.

---
 rtl/jam_cost_table.sv | 164 ++++++++++++++++
 tb/tb_jam_cost_table.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/jam_cost_table.sv
// jam_cost_table
// Cost store for the job-assignment solver. A streaming load port fills an
// N x N worker/job cost matrix in row-major order (index = W*N + J). Once the
// whole matrix is in, the solver's (W, J) lookups are answered on Cost with
// one cycle of latency.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   load_start   one-cycle pulse: start, or restart, a matrix load
//   load_valid   load_data is valid this cycle
//   load_data    one cost entry (row-major order)
//   load_ready   table accepts load_data this cycle (LOADING)
//   W, J         worker / job index from the solver
//   Cost         registered cost for the (W, J) of the previous cycle
//   table_ready  full matrix loaded, lookups valid
//   load_count   entries accepted in the current load (0..N*N)
//   sum_total    sum of all entries accepted in the current load
module jam_cost_table #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 13
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [COST_W-1:0]    load_data,
  output logic                 load_ready,
  input  logic [IDX_W-1:0]     W,
  input  logic [IDX_W-1:0]     J,
  output logic [COST_W-1:0]    Cost,
  output logic                 table_ready,
  output logic [IDX_W*2:0]     load_count,
  output logic [SUM_W-1:0]     sum_total
);

  localparam int CNT_W = IDX_W * 2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                accept_s;
  logic                load_ready_s;
  logic                table_ready_s;
  logic [COST_W-1:0]   cost_s;
  logic                load_ready_r;
  logic                table_ready_r;
  logic [COST_W-1:0]   cost_r;
  logic [CNT_W-1:0]    load_count_r;
  logic [SUM_W-1:0]    sum_total_r;
  logic [COST_W-1:0]   mem_r [N*N];

  // load_start always wins over a same-cycle entry, which is then discarded.
  assign accept_s = (state_r == ST_LOADING) && load_valid && !load_start;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_LOADING: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else if (accept_s && (load_count_r == CNT_LAST)) begin
          next_state_s = ST_READY;
        end else begin
          next_state_s = ST_LOADING;
        end
      end
      ST_READY: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else begin
          next_state_s = ST_READY;
        end
      end
      default: begin
        next_state_s = ST_EMPTY;
      end
    endcase
  end

  // Output decode: flags follow the state being entered so they are valid
  // from the first cycle of that state; Cost is forced to zero as soon as a
  // reload begins.
  always_comb begin
    load_ready_s  = 1'b0;
    table_ready_s = 1'b0;
    cost_s        = '0;
    case (next_state_s)
      ST_LOADING: load_ready_s  = 1'b1;
      ST_READY:   table_ready_s = 1'b1;
      default: begin
        load_ready_s  = 1'b0;
        table_ready_s = 1'b0;
      end
    endcase
    if ((state_r == ST_READY) && !load_start) begin
      cost_s = mem_r[{W, J}];
    end else begin
      cost_s = '0;
    end
  end

  // Registered outputs and load progress counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      load_ready_r  <= 1'b0;
      table_ready_r <= 1'b0;
      cost_r        <= '0;
      load_count_r  <= '0;
      sum_total_r   <= '0;
    end else begin
      load_ready_r  <= load_ready_s;
      table_ready_r <= table_ready_s;
      cost_r        <= cost_s;
      if (load_start) begin
        load_count_r <= '0;
        sum_total_r  <= '0;
      end else if (accept_s) begin
        load_count_r <= load_count_r + CNT_ONE;
        sum_total_r  <= sum_total_r + SUM_W'(load_data);
      end
    end
  end

  // Matrix storage; not reset, contents only matter once a load completes.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      mem_r[load_count_r[CNT_W-2:0]] <= load_data;
    end
  end

  assign load_ready  = load_ready_r;
  assign table_ready = table_ready_r;
  assign Cost        = cost_r;
  assign load_count  = load_count_r;
  assign sum_total   = sum_total_r;

endmodule

// File: tb/tb_jam_cost_table.sv
// Self-checking bench for jam_cost_table: expected lookup costs are pushed to
// a queue as W/J are driven and popped when Cost is sampled a cycle later.
module tb_jam_cost_table;

  logic        CLK;
  logic        RST;
  logic        load_start;
  logic        load_valid;
  logic [6:0]  load_data;
  logic        load_ready;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        table_ready;
  logic [6:0]  load_count;
  logic [12:0] sum_total;

  int          tests;
  int          fails;
  logic [6:0]  exp_mem [64];
  logic [6:0]  exp_q [$];
  int          exp_sum;

  jam_cost_table #(.N(8), .IDX_W(3), .COST_W(7), .SUM_W(13)) dut (
    .CLK(CLK), .RST(RST), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .W(W), .J(J), .Cost(Cost),
    .table_ready(table_ready), .load_count(load_count), .sum_total(sum_total)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full load with load_start pulse; kind 0: index mod 128, 1: all 127, 2: all 1.
  task automatic load_matrix(input int kind, input bit gapped, input bit valid_on_start);
    logic [6:0] v;
    load_start = 1'b1; load_valid = valid_on_start; load_data = 7'd99;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    tests++; if (load_count !== 7'd0) begin fails++; $display("FAIL start_count: got %0d expected 0", load_count); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL start_ready: got %0b expected 1", load_ready); end
    exp_sum = 0;
    for (int i = 0; i < 64; i++) begin
      v = (kind == 0) ? 7'(i % 128) : (kind == 1) ? 7'd127 : 7'd1;
      exp_mem[i] = v;
      exp_sum += v;
      if (gapped) begin
        load_valid = 1'b0;
        tick();
      end
      if (i == 63) begin
        tests++; if (table_ready !== 1'b0) begin fails++; $display("FAIL early_table_ready: got %0b expected 0", table_ready); end
      end
      load_valid = 1'b1; load_data = v;
      tick();
    end
    load_valid = 1'b0;
    tests++; if (load_count !== 7'd64) begin fails++; $display("FAIL load_count: got %0d expected 64", load_count); end
    tests++; if (sum_total !== 13'(exp_sum)) begin fails++; $display("FAIL sum_total: got %0d expected %0d", sum_total, exp_sum); end
    tests++; if (table_ready !== 1'b1) begin fails++; $display("FAIL table_ready: got %0b expected 1", table_ready); end
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_done: got %0b expected 0", load_ready); end
  endtask

  // Drive one (W,J) per cycle; the expected cost is queued and checked next cycle.
  task automatic lookup(input logic [2:0] w, input logic [2:0] j);
    logic [5:0] idx;
    logic [6:0] e;
    idx = {w, j};
    W = w; J = j;
    exp_q.push_back(exp_mem[idx]);
    tick();
    e = exp_q.pop_front();
    tests++; if (Cost !== e) begin fails++; $display("FAIL lookup(%0d,%0d): got %0d expected %0d", w, j, Cost, e); end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++; if ({table_ready, load_ready} !== 2'b00) begin fails++; $display("FAIL idle_flags: got %b expected 00", {table_ready, load_ready}); end
      tests++; if (Cost !== 7'd0) begin fails++; $display("FAIL idle_cost: got %0d expected 0", Cost); end
      tests++; if (load_count !== 7'd0) begin fails++; $display("FAIL idle_count: got %0d expected 0", load_count); end
      tests++; if (sum_total !== 13'd0) begin fails++; $display("FAIL idle_sum: got %0d expected 0", sum_total); end
    end
  endtask

  task automatic test_full_load();
    load_matrix(0, 1'b0, 1'b0);
    tests++; if (sum_total !== 13'd2016) begin fails++; $display("FAIL full_sum: got %0d expected 2016", sum_total); end
    lookup(3'd0, 3'd0);
    tests++; if (Cost !== 7'd0) begin fails++; $display("FAIL cost_00: got %0d expected 0", Cost); end
    lookup(3'd7, 3'd7);
    tests++; if (Cost !== 7'd63) begin fails++; $display("FAIL cost_77: got %0d expected 63", Cost); end
    lookup(3'd3, 3'd5);
    tests++; if (Cost !== 7'd29) begin fails++; $display("FAIL cost_35: got %0d expected 29", Cost); end
    for (int k = 0; k < 8; k++) lookup(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic test_gapped_load();
    load_matrix(1, 1'b1, 1'b0);
    tests++; if (sum_total !== 13'd8128) begin fails++; $display("FAIL gapped_sum: got %0d expected 8128", sum_total); end
    for (int k = 0; k < 10; k++) lookup(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic test_restart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1; load_data = 7'd5;
      tick();
    end
    load_valid = 1'b0;
    tests++; if (load_count !== 7'd20) begin fails++; $display("FAIL partial_count: got %0d expected 20", load_count); end
    tests++; if (sum_total !== 13'd100) begin fails++; $display("FAIL partial_sum: got %0d expected 100", sum_total); end
    // Restart with a simultaneous valid entry, which must be discarded.
    load_matrix(2, 1'b0, 1'b1);
    tests++; if (sum_total !== 13'd64) begin fails++; $display("FAIL restart_sum: got %0d expected 64", sum_total); end
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) lookup(3'(w), 3'(j));
  endtask

  task automatic test_reload_reset();
    W = 3'd2; J = 3'd6;
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests++; if (table_ready !== 1'b0) begin fails++; $display("FAIL reload_table_ready: got %0b expected 0", table_ready); end
    tests++; if (Cost !== 7'd0) begin fails++; $display("FAIL reload_cost: got %0d expected 0", Cost); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reload_load_ready: got %0b expected 1", load_ready); end
    tests++; if (sum_total !== 13'd0) begin fails++; $display("FAIL reload_sum: got %0d expected 0", sum_total); end
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = 7'd9;
      tick();
    end
    tests++; if (load_count !== 7'd5) begin fails++; $display("FAIL midload_count: got %0d expected 5", load_count); end
    #2 RST = 1'b0;
    #1;
    tests++; if ({load_ready, table_ready} !== 2'b00) begin fails++; $display("FAIL async_flags: got %b expected 00", {load_ready, table_ready}); end
    tests++; if (load_count !== 7'd0) begin fails++; $display("FAIL async_count: got %0d expected 0", load_count); end
    tests++; if (sum_total !== 13'd0) begin fails++; $display("FAIL async_sum: got %0d expected 0", sum_total); end
    tests++; if (Cost !== 7'd0) begin fails++; $display("FAIL async_cost: got %0d expected 0", Cost); end
    tick();
    RST = 1'b1;
    // EMPTY ignores load_valid until a new load_start arrives.
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 7'd3;
      tick();
    end
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL empty_load_ready: got %0b expected 0", load_ready); end
    tests++; if (load_count !== 7'd0) begin fails++; $display("FAIL empty_count: got %0d expected 0", load_count); end
    tests++; if (sum_total !== 13'd0) begin fails++; $display("FAIL empty_sum: got %0d expected 0", sum_total); end
  endtask

  initial begin
    tests = 0; fails = 0;
    RST = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 7'd0;
    W = 3'd0; J = 3'd0;
    test_reset();
    test_full_load();
    test_gapped_load();
    test_restart();
    test_reload_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
